// File: rtl/modulation_multiplier_if.sv
// Bundle for the modulation multiplier: swapchain controls, BRAM read port,
// and the intensity/phase sample stream in both directions.
interface modulation_multiplier_if #(
    parameter int NumSegment = 2,
    parameter int DepthBits  = 15
);
    logic                            SEGMENT;
    logic                            STOP;
    logic [DepthBits*NumSegment-1:0] IDX;
    logic [DepthBits:0]              MOD_ADDR;
    logic [7:0]                      MOD_DATA;
    logic                            DIN_VALID;
    logic [7:0]                      INTENSITY_IN;
    logic [7:0]                      PHASE_IN;
    logic                            DOUT_VALID;
    logic [7:0]                      INTENSITY_OUT;
    logic [7:0]                      PHASE_OUT;
    logic [7:0]                      MOD_CUR;

    modport master (
        output SEGMENT, STOP, IDX, MOD_DATA, DIN_VALID, INTENSITY_IN, PHASE_IN,
        input  MOD_ADDR, DOUT_VALID, INTENSITY_OUT, PHASE_OUT, MOD_CUR
    );

    modport slave (
        input  SEGMENT, STOP, IDX, MOD_DATA, DIN_VALID, INTENSITY_IN, PHASE_IN,
        output MOD_ADDR, DOUT_VALID, INTENSITY_OUT, PHASE_OUT, MOD_CUR
    );
endinterface

// File: rtl/modulation_multiplier.sv
// Scales each intensity sample by the per-frame modulation value fetched from BRAM;
// phase rides alongside through a fixed 4-cycle pipeline.
module modulation_multiplier #(
    parameter int  NumSegment = 2,
    parameter int  DepthBits  = 15,
    localparam int Latency    = 4
) (
    input logic                   CLK,
    input logic                   RST_N,
    modulation_multiplier_if.slave bus
);
    logic [DepthBits:0]   r_mod_addr;
    logic [1:0]           r_tag_vld;
    logic [7:0]           r_mod_fetched;
    logic [7:0]           r_mod_frame;
    logic                 r_din_vld_d;
    logic [DepthBits-1:0] w_idx;
    logic                 w_frame_start;
    logic [7:0]           w_mod_use;

    logic [7:0]           r_s1_int;
    logic [8:0]           r_s1_scale;
    logic [16:0]          r_s2_prod;
    logic [7:0]           r_s3_res;
    logic [7:0]           r_int_out;
    logic [Latency-1:0]   r_vld;
    logic [7:0]           r_ph [Latency];

    always_comb begin
        // NOTE: default first so a segment value matching no slot cannot infer a latch.
        w_idx = '0;
        for (int s = 0; s < NumSegment; s++) begin
            if (int'(bus.SEGMENT) == s) w_idx = bus.IDX[s*DepthBits +: DepthBits];
        end
    end

    assign w_frame_start = bus.DIN_VALID & ~r_din_vld_d;
    // The first sample of a burst must see the value being loaded this very cycle.
    assign w_mod_use     = w_frame_start ? r_mod_fetched : r_mod_frame;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mod_addr    <= '0;
            r_tag_vld     <= '0;
            r_mod_fetched <= '0;
            r_mod_frame   <= '0;
            r_din_vld_d   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every read below sees the pre-edge value.
            if (!bus.STOP) r_mod_addr <= {bus.SEGMENT, w_idx};
            r_tag_vld   <= {r_tag_vld[0], ~bus.STOP};
            if (r_tag_vld[1]) r_mod_fetched <= bus.MOD_DATA;
            r_din_vld_d <= bus.DIN_VALID;
            if (w_frame_start) r_mod_frame <= r_mod_fetched;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_int   <= '0;
            r_s1_scale <= '0;
            r_s2_prod  <= '0;
            r_s3_res   <= '0;
            r_int_out  <= '0;
            r_vld      <= '0;
            // NOTE: the phase delay line is cleared too, so a reset mid-burst leaves nothing to leak out.
            for (int i = 0; i < Latency; i++) r_ph[i] <= '0;
        end else begin
            r_s1_int   <= bus.INTENSITY_IN;
            r_s1_scale <= {1'b0, w_mod_use} + 9'd1;
            r_s2_prod  <= 17'(r_s1_int) * 17'(r_s1_scale);
            r_s3_res   <= 8'(r_s2_prod >> 8);
            r_int_out  <= r_vld[Latency-2] ? r_s3_res : '0;
            r_vld      <= {r_vld[Latency-2:0], bus.DIN_VALID};
            r_ph[0]    <= bus.PHASE_IN;
            for (int i = 1; i < Latency - 1; i++) r_ph[i] <= r_ph[i-1];
            r_ph[Latency-1] <= r_vld[Latency-2] ? r_ph[Latency-2] : '0;
        end
    end

    assign bus.MOD_ADDR      = r_mod_addr;
    assign bus.DOUT_VALID    = r_vld[Latency-1];
    assign bus.INTENSITY_OUT = r_int_out;
    assign bus.PHASE_OUT     = r_ph[Latency-1];
    assign bus.MOD_CUR       = r_mod_frame;
endmodule

// File: tb/tb_modulation_multiplier.sv
// Directed bench for modulation_multiplier: a table of per-cycle vectors with
// hand-computed expected outputs, replayed against a 1-cycle registered BRAM model.
module tb_modulation_multiplier;
    localparam int NumSegment = 2;
    localparam int DepthBits  = 15;

    typedef struct {
        logic        v;
        logic [7:0]  din;
        logic [7:0]  ph;
        logic        seg;
        logic        stop;
        logic [14:0] idx0;
        logic [14:0] idx1;
        logic [7:0]  eo;
        logic [7:0]  em;
        logic [15:0] ea;
    } vec_t;

    typedef struct {
        logic        dv;
        logic [7:0]  io;
        logic [7:0]  po;
        logic [7:0]  mc;
        logic [15:0] ma;
    } obs_t;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_vec = 0;
    int   n_err = 0;

    vec_t vq[$];
    obs_t oq[$];
    logic        g_seg, g_stop;
    logic [14:0] g_idx0, g_idx1;

    always #5 CLK = ~CLK;

    modulation_multiplier_if #(.NumSegment(NumSegment), .DepthBits(DepthBits)) mm_if ();

    modulation_multiplier #(.NumSegment(NumSegment), .DepthBits(DepthBits)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (mm_if)
    );

    function automatic logic [7:0] bram_val(input logic [15:0] a);
        case (a)
            16'h0005: return 8'd128;
            16'h0006: return 8'd64;
            16'h0007: return 8'd0;
            16'h0008: return 8'd255;
            16'h8000: return 8'd32;
            default:  return 8'h5A;
        endcase
    endfunction

    always @(posedge CLK) mm_if.MOD_DATA <= bram_val(mm_if.MOD_ADDR);

    task automatic add(input int n, input logic v, input logic [7:0] din, input logic [7:0] ph,
                       input logic [7:0] eo, input logic [7:0] em, input logic [15:0] ea);
        vec_t t;
        for (int i = 0; i < n; i++) begin
            t.v = v; t.din = din; t.ph = ph + 8'(i);
            t.seg = g_seg; t.stop = g_stop; t.idx0 = g_idx0; t.idx1 = g_idx1;
            t.eo = eo; t.em = em; t.ea = ea;
            vq.push_back(t);
        end
    endtask

    // Vector k is driven at negedge k; its MOD_ADDR/MOD_CUR are seen at negedge k+1
    // and its output sample at negedge k+4.
    task automatic play();
        obs_t z;
        z = '{default: '0};
        oq.delete();
        for (int i = 0; i < vq.size(); i++) oq.push_back(z);
        for (int k = 0; k < vq.size() + 4; k++) begin
            @(negedge CLK);
            if (k >= 4) begin
                oq[k-4].dv = mm_if.DOUT_VALID;
                oq[k-4].io = mm_if.INTENSITY_OUT;
                oq[k-4].po = mm_if.PHASE_OUT;
            end
            if (k >= 1 && k <= vq.size()) begin
                oq[k-1].mc = mm_if.MOD_CUR;
                oq[k-1].ma = mm_if.MOD_ADDR;
            end
            if (k < vq.size()) begin
                mm_if.DIN_VALID    = vq[k].v;
                mm_if.INTENSITY_IN = vq[k].din;
                mm_if.PHASE_IN     = vq[k].ph;
                mm_if.SEGMENT      = vq[k].seg;
                mm_if.STOP         = vq[k].stop;
                mm_if.IDX          = {vq[k].idx1, vq[k].idx0};
            end else begin
                mm_if.DIN_VALID    = 1'b0;
                mm_if.INTENSITY_IN = '0;
                mm_if.PHASE_IN     = '0;
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        n_vec++; if (mm_if.DOUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset dout_valid got %b want 0", mm_if.DOUT_VALID); end
        n_vec++; if (mm_if.INTENSITY_OUT !== 8'h00) begin n_err++; $display("FAIL reset intensity_out got %h want 00", mm_if.INTENSITY_OUT); end
        n_vec++; if (mm_if.PHASE_OUT !== 8'h00) begin n_err++; $display("FAIL reset phase_out got %h want 00", mm_if.PHASE_OUT); end
        n_vec++; if (mm_if.MOD_CUR !== 8'h00) begin n_err++; $display("FAIL reset mod_cur got %h want 00", mm_if.MOD_CUR); end
        n_vec++; if (mm_if.MOD_ADDR !== 16'h0000) begin n_err++; $display("FAIL reset mod_addr got %h want 0000", mm_if.MOD_ADDR); end
        RST_N = 1'b1;
    endtask

    task automatic test_basic();
        vq.delete();
        g_idx0 = 15'd5;
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0005);
        add(249, 1'b1, 8'd200, 8'h00, 8'd100, 8'd128, 16'h0005);
        play();
        for (int k = 0; k < vq.size(); k++) begin
            n_vec++; if (oq[k].dv !== vq[k].v) begin n_err++; $display("FAIL basic dout_valid[%0d] got %b want %b", k, oq[k].dv, vq[k].v); end
            n_vec++; if (oq[k].io !== (vq[k].v ? vq[k].eo : 8'h00)) begin n_err++; $display("FAIL basic intensity_out[%0d] got %0d want %0d", k, oq[k].io, vq[k].v ? vq[k].eo : 8'h00); end
            n_vec++; if (oq[k].po !== (vq[k].v ? vq[k].ph : 8'h00)) begin n_err++; $display("FAIL basic phase_out[%0d] got %h want %h", k, oq[k].po, vq[k].v ? vq[k].ph : 8'h00); end
            if (vq[k].v) begin n_vec++; if (oq[k].mc !== vq[k].em) begin n_err++; $display("FAIL basic mod_cur[%0d] got %0d want %0d", k, oq[k].mc, vq[k].em); end end
        end
    endtask

    task automatic test_mod_extremes();
        vq.delete();
        g_idx0 = 15'd7;
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0007);
        add(3, 1'b1, 8'd255, 8'h3C, 8'd0, 8'd0, 16'h0007);
        g_idx0 = 15'd8;
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0008);
        add(3, 1'b1, 8'd255, 8'h3C, 8'd255, 8'd255, 16'h0008);
        play();
        for (int k = 0; k < vq.size(); k++) begin
            n_vec++; if (oq[k].dv !== vq[k].v) begin n_err++; $display("FAIL extremes dout_valid[%0d] got %b want %b", k, oq[k].dv, vq[k].v); end
            n_vec++; if (oq[k].io !== (vq[k].v ? vq[k].eo : 8'h00)) begin n_err++; $display("FAIL extremes intensity_out[%0d] got %0d want %0d", k, oq[k].io, vq[k].v ? vq[k].eo : 8'h00); end
            n_vec++; if (oq[k].po !== (vq[k].v ? vq[k].ph : 8'h00)) begin n_err++; $display("FAIL extremes phase_out[%0d] got %h want %h", k, oq[k].po, vq[k].v ? vq[k].ph : 8'h00); end
            if (vq[k].v) begin n_vec++; if (oq[k].mc !== vq[k].em) begin n_err++; $display("FAIL extremes mod_cur[%0d] got %0d want %0d", k, oq[k].mc, vq[k].em); end end
        end
    endtask

    task automatic test_midburst_idx();
        vq.delete();
        g_idx0 = 15'd5;
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0005);
        add(100, 1'b1, 8'd200, 8'h00, 8'd100, 8'd128, 16'h0005);
        g_idx0 = 15'd6;
        add(100, 1'b1, 8'd200, 8'd100, 8'd100, 8'd128, 16'h0006);
        add(1, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0006);
        add(10, 1'b1, 8'd200, 8'h10, 8'd50, 8'd64, 16'h0006);
        play();
        for (int k = 0; k < vq.size(); k++) begin
            n_vec++; if (oq[k].dv !== vq[k].v) begin n_err++; $display("FAIL midburst dout_valid[%0d] got %b want %b", k, oq[k].dv, vq[k].v); end
            n_vec++; if (oq[k].io !== (vq[k].v ? vq[k].eo : 8'h00)) begin n_err++; $display("FAIL midburst intensity_out[%0d] got %0d want %0d", k, oq[k].io, vq[k].v ? vq[k].eo : 8'h00); end
            n_vec++; if (oq[k].ma !== vq[k].ea) begin n_err++; $display("FAIL midburst mod_addr[%0d] got %h want %h", k, oq[k].ma, vq[k].ea); end
            if (vq[k].v) begin n_vec++; if (oq[k].mc !== vq[k].em) begin n_err++; $display("FAIL midburst mod_cur[%0d] got %0d want %0d", k, oq[k].mc, vq[k].em); end end
        end
    endtask

    task automatic test_stop();
        vq.delete();
        g_stop = 1'b1;
        g_idx0 = 15'd5;
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0006);
        add(5, 1'b1, 8'd200, 8'h20, 8'd50, 8'd64, 16'h0006);
        g_stop = 1'b0;
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0005);
        add(5, 1'b1, 8'd200, 8'h30, 8'd100, 8'd128, 16'h0005);
        play();
        for (int k = 0; k < vq.size(); k++) begin
            n_vec++; if (oq[k].ma !== vq[k].ea) begin n_err++; $display("FAIL stop mod_addr[%0d] got %h want %h", k, oq[k].ma, vq[k].ea); end
            n_vec++; if (oq[k].io !== (vq[k].v ? vq[k].eo : 8'h00)) begin n_err++; $display("FAIL stop intensity_out[%0d] got %0d want %0d", k, oq[k].io, vq[k].v ? vq[k].eo : 8'h00); end
            if (vq[k].v) begin n_vec++; if (oq[k].mc !== vq[k].em) begin n_err++; $display("FAIL stop mod_cur[%0d] got %0d want %0d", k, oq[k].mc, vq[k].em); end end
        end
    endtask

    task automatic test_segment();
        vq.delete();
        g_seg  = 1'b1;
        g_idx1 = 15'd0;
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h8000);
        add(5, 1'b1, 8'd200, 8'h40, 8'd25, 8'd32, 16'h8000);
        g_seg  = 1'b0;
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0005);
        add(2, 1'b1, 8'd200, 8'h50, 8'd100, 8'd128, 16'h0005);
        play();
        for (int k = 0; k < vq.size(); k++) begin
            n_vec++; if (oq[k].ma !== vq[k].ea) begin n_err++; $display("FAIL segment mod_addr[%0d] got %h want %h", k, oq[k].ma, vq[k].ea); end
            n_vec++; if (oq[k].dv !== vq[k].v) begin n_err++; $display("FAIL segment dout_valid[%0d] got %b want %b", k, oq[k].dv, vq[k].v); end
            n_vec++; if (oq[k].io !== (vq[k].v ? vq[k].eo : 8'h00)) begin n_err++; $display("FAIL segment intensity_out[%0d] got %0d want %0d", k, oq[k].io, vq[k].v ? vq[k].eo : 8'h00); end
            if (vq[k].v) begin n_vec++; if (oq[k].mc !== vq[k].em) begin n_err++; $display("FAIL segment mod_cur[%0d] got %0d want %0d", k, oq[k].mc, vq[k].em); end end
        end
    endtask

    task automatic test_back_to_back();
        vq.delete();
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0005);
        g_idx0 = 15'd8;
        add(1, 1'b1, 8'd100, 8'h61, 8'd50, 8'd128, 16'h0008);
        add(1, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0008);
        add(1, 1'b1, 8'd100, 8'h62, 8'd50, 8'd128, 16'h0008);
        add(1, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0008);
        add(2, 1'b1, 8'd100, 8'h63, 8'd100, 8'd255, 16'h0008);
        play();
        for (int k = 0; k < vq.size(); k++) begin
            n_vec++; if (oq[k].dv !== vq[k].v) begin n_err++; $display("FAIL b2b dout_valid[%0d] got %b want %b", k, oq[k].dv, vq[k].v); end
            n_vec++; if (oq[k].io !== (vq[k].v ? vq[k].eo : 8'h00)) begin n_err++; $display("FAIL b2b intensity_out[%0d] got %0d want %0d", k, oq[k].io, vq[k].v ? vq[k].eo : 8'h00); end
            n_vec++; if (oq[k].po !== (vq[k].v ? vq[k].ph : 8'h00)) begin n_err++; $display("FAIL b2b phase_out[%0d] got %h want %h", k, oq[k].po, vq[k].v ? vq[k].ph : 8'h00); end
            if (vq[k].v) begin n_vec++; if (oq[k].mc !== vq[k].em) begin n_err++; $display("FAIL b2b mod_cur[%0d] got %0d want %0d", k, oq[k].mc, vq[k].em); end end
        end
    endtask

    task automatic test_reset_midburst();
        vq.delete();
        g_idx0 = 15'd5;
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0005);
        play();
        mm_if.IDX = {g_idx1, g_idx0};
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            mm_if.DIN_VALID    = 1'b1;
            mm_if.INTENSITY_IN = 8'd200;
            mm_if.PHASE_IN     = 8'(k);
        end
        @(negedge CLK);
        n_vec++; if (mm_if.DOUT_VALID !== 1'b1) begin n_err++; $display("FAIL rstmid pre dout_valid got %b want 1", mm_if.DOUT_VALID); end
        RST_N = 1'b0;
        #1;
        n_vec++; if (mm_if.DOUT_VALID !== 1'b0) begin n_err++; $display("FAIL rstmid dout_valid got %b want 0", mm_if.DOUT_VALID); end
        n_vec++; if (mm_if.INTENSITY_OUT !== 8'h00) begin n_err++; $display("FAIL rstmid intensity_out got %h want 00", mm_if.INTENSITY_OUT); end
        n_vec++; if (mm_if.PHASE_OUT !== 8'h00) begin n_err++; $display("FAIL rstmid phase_out got %h want 00", mm_if.PHASE_OUT); end
        n_vec++; if (mm_if.MOD_CUR !== 8'h00) begin n_err++; $display("FAIL rstmid mod_cur got %h want 00", mm_if.MOD_CUR); end
        n_vec++; if (mm_if.MOD_ADDR !== 16'h0000) begin n_err++; $display("FAIL rstmid mod_addr got %h want 0000", mm_if.MOD_ADDR); end
        repeat (2) @(negedge CLK);
        RST_N           = 1'b1;
        mm_if.DIN_VALID = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            n_vec++; if (mm_if.DOUT_VALID !== 1'b0) begin n_err++; $display("FAIL rstmid stale dout_valid[%0d] got %b want 0", k, mm_if.DOUT_VALID); end
        end
        vq.delete();
        add(4, 1'b0, 8'd0, 8'h00, 8'd0, 8'd0, 16'h0005);
        add(3, 1'b1, 8'd200, 8'h70, 8'd100, 8'd128, 16'h0005);
        play();
        for (int k = 0; k < vq.size(); k++) begin
            n_vec++; if (oq[k].dv !== vq[k].v) begin n_err++; $display("FAIL rstmid post dout_valid[%0d] got %b want %b", k, oq[k].dv, vq[k].v); end
            n_vec++; if (oq[k].io !== (vq[k].v ? vq[k].eo : 8'h00)) begin n_err++; $display("FAIL rstmid post intensity_out[%0d] got %0d want %0d", k, oq[k].io, vq[k].v ? vq[k].eo : 8'h00); end
            if (vq[k].v) begin n_vec++; if (oq[k].mc !== vq[k].em) begin n_err++; $display("FAIL rstmid post mod_cur[%0d] got %0d want %0d", k, oq[k].mc, vq[k].em); end end
        end
    endtask

    initial begin
        g_seg  = 1'b0;
        g_stop = 1'b0;
        g_idx0 = 15'd5;
        g_idx1 = 15'd0;
        mm_if.SEGMENT      = 1'b0;
        mm_if.STOP         = 1'b0;
        mm_if.IDX          = {g_idx1, g_idx0};
        mm_if.DIN_VALID    = 1'b0;
        mm_if.INTENSITY_IN = '0;
        mm_if.PHASE_IN     = '0;

        test_reset();
        test_basic();
        test_mod_extremes();
        test_midburst_idx();
        test_stop();
        test_segment();
        test_back_to_back();
        test_reset_midburst();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/modulation_multiplier.md
MODULATION_MULTIPLIER -- requirements
Module: modulation_multiplier

Interface
REQ-001 Parameters SHALL be: NumSegment, default 2, number of modulation segments; DepthBits, default 15, index width per segment; Latency, default 4, fixed DIN-to-DOUT delay in cycles (not overridable by users).
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  CLK  in  1  system clock; the only clock
  RST_N  in  1  reset, asynchronous, active-low
  SEGMENT  in  1  active segment from the modulation swapchain
  STOP  in  1  swapchain finite-loop end flag
  IDX  in  15 x NumSegment  current sample index per segment
  MOD_ADDR  out  16  BRAM read address {segment, index}
  MOD_DATA  in  8  BRAM read data; valid 2 cycles after MOD_ADDR
  DIN_VALID  in  1  intensity/phase sample strobe; high for a contiguous burst (one frame)
  INTENSITY_IN  in  8  raw intensity
  PHASE_IN  in  8  phase, passed through
  DOUT_VALID  out  1  output strobe
  INTENSITY_OUT  out  8  modulated intensity
  PHASE_OUT  out  8  delayed phase
  MOD_CUR  out  8  modulation value applied to the current/last frame (debug)

Function
REQ-003 MOD_ADDR SHALL be registered each cycle as {SEGMENT, IDX[SEGMENT]} while STOP=0; while STOP=1 MOD_ADDR SHALL hold its last value.
REQ-004 A 2-stage tag pipeline SHALL track MOD_ADDR so mod_fetched is updated with MOD_DATA exactly 2 cycles after each address was issued; no other MOD_DATA sample is used.
REQ-005 Frame start SHALL be detected as DIN_VALID=1 with DIN_VALID=0 in the previous cycle; on that cycle mod_frame SHALL be loaded from mod_fetched and held for the entire burst.
REQ-006 mod_frame SHALL NOT change during a burst even if SEGMENT, IDX or STOP change mid-burst; changes take effect at the next frame start.
REQ-007 Output arithmetic SHALL be INTENSITY_OUT = (INTENSITY_IN * (mod_frame + 1)) >> 8, unsigned, 8x9-bit product 17 bits wide, upper bits truncated, no rounding; mod=0 yields 0, mod=255 yields INTENSITY_IN unchanged.
REQ-008 The data path SHALL be a fixed pipeline of Latency=4 cycles: DOUT_VALID, INTENSITY_OUT and PHASE_OUT SHALL reflect the sample presented Latency cycles earlier, one output per input, no stalls, no backpressure.
REQ-009 For the first sample of a burst, the multiplier SHALL use the mod_frame value loaded that same cycle (bypass), not the previous frame's value.
REQ-010 PHASE_OUT SHALL equal PHASE_IN delayed by Latency cycles, unmodified.
REQ-011 When DOUT_VALID=0, INTENSITY_OUT and PHASE_OUT SHALL be 0.
REQ-012 MOD_CUR SHALL equal mod_frame.
REQ-013 A SEGMENT toggle SHALL change MOD_ADDR's MSB on the next cycle; the new segment's value is visible in mod_fetched 3 cycles after the toggle.
REQ-014 A burst of length 1 and back-to-back bursts separated by a single DIN_VALID=0 cycle SHALL each be treated as distinct frames with their own mod_frame load.

Reset
REQ-015 On RST_N=0, asynchronously: MOD_ADDR=0, mod_fetched=0, mod_frame=0, all pipeline valid bits=0, DOUT_VALID=0, INTENSITY_OUT=0, PHASE_OUT=0, MOD_CUR=0.
REQ-016 Reset asserted mid-burst SHALL discard all in-flight samples; after RST_N rises, the first DIN_VALID=1 cycle SHALL be a frame start; the first valid mod_fetched appears 3 cycles after RST_N release.

Verification
REQ-017 BRAM seg0 addr5=128, SEGMENT=0, IDX[0]=5 steady, burst of 249 samples INTENSITY_IN=200 -> 249 DOUT_VALID cycles starting 4 cycles after burst start, INTENSITY_OUT=100 each, MOD_CUR=128.
REQ-018 mod=0 and mod=255 with INTENSITY_IN=255, PHASE_IN=0x3C -> INTENSITY_OUT 0 and 255 respectively, PHASE_OUT=0x3C.
REQ-019 IDX[0] changes 5->6 (mod 128->64) at burst cycle 100 -> whole burst uses 128; next burst uses 64.
REQ-020 STOP=1 with IDX then moving -> MOD_ADDR frozen, subsequent frames keep the last value; STOP=0 -> address follows IDX again.
REQ-021 SEGMENT 0->1 between bursts with seg1 addr0=32, IDX[1]=0 -> MOD_ADDR=0x8000 next cycle, next frame MOD_CUR=32.
REQ-022 RST_N pulsed low at burst cycle 10 -> DOUT_VALID low immediately, outputs 0, no stale samples emitted after release.
